// File: rtl/cpu8_wb_bridge.sv
// Byte-wide CPU port to 32-bit Wishbone master bridge with a single-word
// read buffer, write-through byte stores and a programmable bus timeout.
module cpu8_wb_bridge #(
    parameter int APP_AW = 26,
    parameter int TMO_W  = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [APP_AW-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    input  logic              flush,
    input  logic [TMO_W-1:0]  cfg_timeout,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [APP_AW-1:0] wb_addr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    output logic [2:0]        wb_cti_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]       buf_data;
    logic [APP_AW-3:0] buf_tag;
    logic              buf_valid;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  tmo_next;
    logic [1:0]        lane;
    logic [7:0]        rdata_q;
    logic              err_q;
    logic              hit;
    logic              tmo_hit;
    logic              tag_match_bus;

    assign hit           = buf_valid && (buf_tag == cpu_addr[APP_AW-1:2]);
    assign tag_match_bus = buf_valid && (buf_tag == wb_addr_o[APP_AW-1:2]);
    assign tmo_next      = tmo_cnt + 1'b1;
    // Fires at the end of the BUS cycle that brings the count up to cfg_timeout.
    assign tmo_hit       = (cfg_timeout != '0) && (tmo_next == cfg_timeout);
    assign wb_cti_o      = 3'b000;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wb_cyc_o   = 1'b0;
        wb_stb_o   = 1'b0;
        cpu_ack    = 1'b0;
        cpu_err    = 1'b0;
        cpu_rdata  = 8'h00;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    state_next = (!cpu_we && hit) ? DONE : BUS;
                end
            end
            BUS: begin
                wb_cyc_o = 1'b1;
                wb_stb_o = 1'b1;
                if (wb_ack_i || tmo_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                cpu_ack    = 1'b1;
                cpu_err    = err_q;
                cpu_rdata  = rdata_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            wb_we_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= 4'h0;
            buf_data  <= '0;
            buf_tag   <= '0;
            buf_valid <= 1'b0;
            tmo_cnt   <= '0;
            lane      <= 2'd0;
            rdata_q   <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        lane  <= cpu_addr[1:0];
                        err_q <= 1'b0;
                        if (!cpu_we && hit) begin
                            rdata_q <= buf_data[{cpu_addr[1:0], 3'b000} +: 8];
                        end else begin
                            wb_addr_o <= {cpu_addr[APP_AW-1:2], 2'b00};
                            wb_we_o   <= cpu_we;
                            wb_sel_o  <= cpu_we ? (4'b0001 << cpu_addr[1:0]) : 4'hF;
                            wb_dat_o  <= {4{cpu_wdata}};
                            tmo_cnt   <= '0;
                        end
                    end
                end
                BUS: begin
                    tmo_cnt <= tmo_next;
                    // An ack in the same cycle as the timeout takes priority.
                    if (wb_ack_i) begin
                        if (!wb_we_o) begin
                            buf_data  <= wb_dat_i;
                            buf_tag   <= wb_addr_o[APP_AW-1:2];
                            buf_valid <= 1'b1;
                            rdata_q   <= wb_dat_i[{lane, 3'b000} +: 8];
                        end else begin
                            rdata_q <= 8'h00;
                            if (tag_match_bus) begin
                                buf_data[{lane, 3'b000} +: 8] <= wb_dat_o[7:0];
                            end
                        end
                    end else if (tmo_hit) begin
                        err_q     <= 1'b1;
                        rdata_q   <= 8'h00;
                        buf_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (flush) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu8_wb_bridge.sv
// Directed, table-driven self-checking bench for cpu8_wb_bridge, with
// hand-written sequences for reset corner cases.
module tb_cpu8_wb_bridge;

    localparam int AW = 26;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          wb_rst_n;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic [7:0]    cpu_rdata;
    logic          cpu_ack;
    logic          cpu_err;
    logic          flush;
    logic [TW-1:0] cfg_timeout;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [31:0]   wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic [2:0]    wb_cti_o;
    logic [31:0]   wb_dat_i;
    logic          wb_ack_i;

    int num_checks = 0;
    int num_errors = 0;

    always #5 clk = ~clk;

    cpu8_wb_bridge #(.APP_AW(AW), .TMO_W(TW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n   (wb_rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .cpu_err    (cpu_err),
        .flush      (flush),
        .cfg_timeout(cfg_timeout),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_addr_o  (wb_addr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_cti_o   (wb_cti_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    typedef struct {
        string         name;
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        logic [TW-1:0] cfg;
        int            ack_cyc;
        logic [31:0]   sdata;
        bit            pre_flush;
        bit            flush_ack;
        int            exp_lat;
        int            exp_bus;
        logic [AW-1:0] exp_addr;
        logic [3:0]    exp_sel;
        logic [31:0]   exp_dat;
        logic [7:0]    exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic we, input logic [AW-1:0] addr, input logic [7:0] wdata);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
    endtask

    // Drives one CPU transaction and plays the Wishbone slave, acking in BUS cycle ack_cyc.
    task automatic run_vec(input vec_t v);
        int            lat = 0;
        int            acks = 0;
        int            bus_n = 0;
        logic [7:0]    rdata_at_ack = 8'h00;
        logic          err_at_ack = 1'b0;
        logic [AW-1:0] a0 = '0;
        logic [3:0]    s0 = 4'h0;
        logic          we0 = 1'b0;
        logic [31:0]   d0 = '0;
        bit            stable = 1'b1;
        bit            quiet = 1'b1;
        cfg_timeout = v.cfg;
        if (v.pre_flush) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
        applyStimulus(1'b1, v.we, v.addr, v.wdata);
        for (int c = 1; c <= 40 && acks == 0; c++) begin
            step();
            wb_ack_i = 1'b0;
            wb_dat_i = 32'hDEADBEEF;
            flush    = 1'b0;
            if (cpu_ack) begin
                acks++;
                lat          = c;
                rdata_at_ack = cpu_rdata;
                err_at_ack   = cpu_err;
                cpu_req      = 1'b0;
            end else if (cpu_rdata !== 8'h00 || cpu_err !== 1'b0) begin
                quiet = 1'b0;
            end
            if (wb_cyc_o) begin
                bus_n++;
                if (bus_n == 1) begin
                    a0 = wb_addr_o; s0 = wb_sel_o; we0 = wb_we_o; d0 = wb_dat_o;
                end else if (a0 !== wb_addr_o || s0 !== wb_sel_o || we0 !== wb_we_o || d0 !== wb_dat_o) begin
                    stable = 1'b0;
                end
                if (wb_stb_o !== 1'b1) stable = 1'b0;
                if (bus_n == v.ack_cyc) begin
                    wb_ack_i = 1'b1;
                    wb_dat_i = v.sdata;
                    flush    = v.flush_ack;
                end
            end
        end
        cpu_req = 1'b0;
        step();
        if (cpu_ack) acks++;
        if (wb_cyc_o) bus_n++;
        checkOutput($sformatf("%s.ack_latency", v.name), lat, v.exp_lat);
        checkOutput($sformatf("%s.ack_count", v.name), acks, 1);
        checkOutput($sformatf("%s.rdata", v.name), {24'h0, rdata_at_ack}, {24'h0, v.exp_rdata});
        checkOutput($sformatf("%s.err", v.name), {31'h0, err_at_ack}, {31'h0, v.exp_err});
        checkOutput($sformatf("%s.bus_cycles", v.name), bus_n, v.exp_bus);
        checkOutput($sformatf("%s.idle_quiet", v.name), {31'h0, quiet}, 32'd1);
        if (v.exp_bus > 0) begin
            checkOutput($sformatf("%s.wb_addr", v.name), {6'h0, a0}, {6'h0, v.exp_addr});
            checkOutput($sformatf("%s.wb_sel", v.name), {28'h0, s0}, {28'h0, v.exp_sel});
            checkOutput($sformatf("%s.wb_we", v.name), {31'h0, we0}, {31'h0, v.we});
            checkOutput($sformatf("%s.bus_stable", v.name), {31'h0, stable}, 32'd1);
            if (v.we) checkOutput($sformatf("%s.wb_dat", v.name), d0, v.exp_dat);
        end
    endtask

    initial begin
        bit quiet;
        wb_rst_n    = 1'b0;
        flush       = 1'b0;
        cfg_timeout = '0;
        wb_ack_i    = 1'b0;
        wb_dat_i    = '0;
        applyStimulus(1'b0, 1'b0, '0, 8'h00);

        //                name           we  addr      wdata  cfg  ack  sdata          pf  fa  lat bus  exp_addr  sel   exp_dat        rdata  err
        vecs.push_back(vec_t'{"rd_miss_105",  1'b0, 26'h105, 8'h00, 8'd0, 3, 32'h44332211, 0, 0, 4, 3, 26'h104, 4'hF, 32'h0,        8'h22, 1'b0});
        vecs.push_back(vec_t'{"rd_hit_107",   1'b0, 26'h107, 8'h00, 8'd0, 0, 32'h0,        0, 0, 1, 0, 26'h0,   4'h0, 32'h0,        8'h44, 1'b0});
        vecs.push_back(vec_t'{"wr_106",       1'b1, 26'h106, 8'hAB, 8'd0, 1, 32'h0,        0, 0, 2, 1, 26'h104, 4'h4, 32'hABABABAB, 8'h00, 1'b0});
        vecs.push_back(vec_t'{"rd_hit_106",   1'b0, 26'h106, 8'h00, 8'd0, 0, 32'h0,        0, 0, 1, 0, 26'h0,   4'h0, 32'h0,        8'hAB, 1'b0});
        vecs.push_back(vec_t'{"rd_hit_104",   1'b0, 26'h104, 8'h00, 8'd0, 0, 32'h0,        0, 0, 1, 0, 26'h0,   4'h0, 32'h0,        8'h11, 1'b0});
        vecs.push_back(vec_t'{"tmo_200",      1'b0, 26'h200, 8'h00, 8'd5, 0, 32'h0,        0, 0, 6, 5, 26'h200, 4'hF, 32'h0,        8'h00, 1'b1});
        vecs.push_back(vec_t'{"rd_105_inval", 1'b0, 26'h105, 8'h00, 8'd0, 1, 32'h99887766, 0, 0, 2, 1, 26'h104, 4'hF, 32'h0,        8'h77, 1'b0});
        vecs.push_back(vec_t'{"rd_miss_201",  1'b0, 26'h201, 8'h00, 8'd0, 1, 32'h87654321, 0, 0, 2, 1, 26'h200, 4'hF, 32'h0,        8'h43, 1'b0});
        vecs.push_back(vec_t'{"rd_hit_203",   1'b0, 26'h203, 8'h00, 8'd0, 0, 32'h0,        0, 0, 1, 0, 26'h0,   4'h0, 32'h0,        8'h87, 1'b0});
        vecs.push_back(vec_t'{"flush_rd_200", 1'b0, 26'h200, 8'h00, 8'd0, 1, 32'hA1B2C3D4, 1, 0, 2, 1, 26'h200, 4'hF, 32'h0,        8'hD4, 1'b0});
        vecs.push_back(vec_t'{"fill_flush",   1'b0, 26'h104, 8'h00, 8'd0, 2, 32'h55667788, 0, 1, 3, 2, 26'h104, 4'hF, 32'h0,        8'h88, 1'b0});
        vecs.push_back(vec_t'{"rd_104_again", 1'b0, 26'h104, 8'h00, 8'd0, 1, 32'h01020304, 0, 0, 2, 1, 26'h104, 4'hF, 32'h0,        8'h04, 1'b0});
        vecs.push_back(vec_t'{"rd_hit_105",   1'b0, 26'h105, 8'h00, 8'd0, 0, 32'h0,        0, 0, 1, 0, 26'h0,   4'h0, 32'h0,        8'h03, 1'b0});
        vecs.push_back(vec_t'{"wr_other_303", 1'b1, 26'h303, 8'h5A, 8'd0, 2, 32'h0,        0, 0, 3, 2, 26'h300, 4'h8, 32'h5A5A5A5A, 8'h00, 1'b0});
        vecs.push_back(vec_t'{"rd_hit_107b",  1'b0, 26'h107, 8'h00, 8'd0, 0, 32'h0,        0, 0, 1, 0, 26'h0,   4'h0, 32'h0,        8'h01, 1'b0});
        vecs.push_back(vec_t'{"wr_107",       1'b1, 26'h107, 8'hC3, 8'd0, 1, 32'h0,        0, 0, 2, 1, 26'h104, 4'h8, 32'hC3C3C3C3, 8'h00, 1'b0});
        vecs.push_back(vec_t'{"rd_hit_107c",  1'b0, 26'h107, 8'h00, 8'd0, 0, 32'h0,        0, 0, 1, 0, 26'h0,   4'h0, 32'h0,        8'hC3, 1'b0});
        vecs.push_back(vec_t'{"ack_vs_tmo",   1'b0, 26'h401, 8'h00, 8'd3, 3, 32'h0000FF00, 0, 0, 4, 3, 26'h400, 4'hF, 32'h0,        8'hFF, 1'b0});
        vecs.push_back(vec_t'{"rd_hit_400",   1'b0, 26'h400, 8'h00, 8'd0, 0, 32'h0,        0, 0, 1, 0, 26'h0,   4'h0, 32'h0,        8'h00, 1'b0});
        vecs.push_back(vec_t'{"tmo_off_slow", 1'b0, 26'h503, 8'h00, 8'd0, 8, 32'hCAFEBABE, 0, 0, 9, 8, 26'h500, 4'hF, 32'h0,        8'hCA, 1'b0});
        vecs.push_back(vec_t'{"tmo_1",        1'b0, 26'h600, 8'h00, 8'd1, 0, 32'h0,        0, 0, 2, 1, 26'h600, 4'hF, 32'h0,        8'h00, 1'b1});
        vecs.push_back(vec_t'{"rd_502_inval", 1'b0, 26'h502, 8'h00, 8'd0, 1, 32'h12345678, 0, 0, 2, 1, 26'h500, 4'hF, 32'h0,        8'h34, 1'b0});

        step();
        step();
        step();
        checkOutput("reset.cyc", {31'h0, wb_cyc_o}, 32'd0);
        checkOutput("reset.stb", {31'h0, wb_stb_o}, 32'd0);
        checkOutput("reset.we", {31'h0, wb_we_o}, 32'd0);
        checkOutput("reset.sel", {28'h0, wb_sel_o}, 32'd0);
        checkOutput("reset.addr", {6'h0, wb_addr_o}, 32'd0);
        checkOutput("reset.dat", wb_dat_o, 32'd0);
        checkOutput("reset.cti", {29'h0, wb_cti_o}, 32'd0);
        checkOutput("reset.ack", {31'h0, cpu_ack}, 32'd0);
        checkOutput("reset.err", {31'h0, cpu_err}, 32'd0);
        checkOutput("reset.rdata", {24'h0, cpu_rdata}, 32'd0);
        wb_rst_n = 1'b1;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of a bus cycle, then a stray slave ack.
        cfg_timeout = '0;
        applyStimulus(1'b1, 1'b0, 26'h701, 8'h00);
        step();
        checkOutput("rst_bus.cyc_before", {31'h0, wb_cyc_o}, 32'd1);
        step();
        wb_rst_n = 1'b0;
        cpu_req  = 1'b0;
        step();
        wb_rst_n = 1'b1;
        checkOutput("rst_bus.cyc", {31'h0, wb_cyc_o}, 32'd0);
        checkOutput("rst_bus.ack", {31'h0, cpu_ack}, 32'd0);
        checkOutput("rst_bus.sel", {28'h0, wb_sel_o}, 32'd0);
        checkOutput("rst_bus.addr", {6'h0, wb_addr_o}, 32'd0);
        step();
        step();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hFFFFFFFF;
        quiet    = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            wb_ack_i = 1'b0;
            if (cpu_ack || cpu_err || wb_cyc_o || cpu_rdata != 8'h00 || wb_sel_o != 4'h0) quiet = 1'b0;
        end
        checkOutput("rst_bus.stray_ack", {31'h0, quiet}, 32'd1);

        run_vec(vec_t'{"post_rst_miss", 1'b0, 26'h501, 8'h00, 8'd0, 1, 32'h0BADF00D, 0, 0, 2, 1, 26'h500, 4'hF, 32'h0, 8'hF0, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
